// File: rtl/uart_rx_fc_pkg.sv
// Shared definitions for the flow-controlled UART receiver: FSM encoding and frame constants.
package uart_rx_fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO; a pop in the same cycle frees the slot for a push into a full buffer.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_ok,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset too, so rx_data reads zero out of reset; cheap at this depth.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_fc.sv
// 8N1 UART receiver with byte FIFO, valid/ready output and RTS flow control.
module uart_rx_fc
    import uart_rx_fc_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic       uart_rts,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int          DIV     = CLK_FREQ / BAUD;
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;

    rx_state_e   state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rxs_q, rxs_d;
    logic        rxs_prev_q, rxs_prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        rts_q, rts_d;

    logic          tick;
    logic          stop_sample;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_next;

    assign tick = (cnt_q == 16'd0);

    // Two-flop synchroniser plus a delayed copy for falling-edge start detection.
    always_comb begin
        rx_meta_d  = uart_rxd;
        rxs_d      = rx_meta_q;
        rxs_prev_d = rxs_q;
        rts_d      = (fifo_count_next <= CW'(FIFO_DEPTH - 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rts_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rts_q      <= rts_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? cnt_q : cnt_q - 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (!rxs_q && rxs_prev_q) begin
                    cnt_d   = HALF_M1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d     = DIV_M1;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    cnt_d     = DIV_M1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stop-bit decision: push, or flag a bad stop bit / a refused push.
    always_comb begin
        stop_sample = (state_q == STOP) && tick;
        push        = stop_sample && (rxs_q == STOP_LEVEL);
        frame_err   = stop_sample && (rxs_q != STOP_LEVEL);
        overrun     = push && !push_ok;
    end

    assign pop      = rx_valid && rx_ready;
    assign rx_valid = !fifo_empty;
    assign uart_rts = rts_q;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (shift_q),
        .push_ok    (push_ok),
        .pop        (pop),
        .rd_data    (rx_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

endmodule
